// File: rtl/writeback_unit.sv
// writeback_unit: captures the execute result a fixed latency after issue, buffers it
// in a small FIFO and drains it into the vector register file write port. A credit
// scheme (queued entries + tags still in flight) stalls issue so no result is lost.
module writeback_unit #(
    parameter int unsigned PE_COUNT       = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned EXEC_LATENCY   = 1,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]             issue_dst,
    input  logic                                  issue_src_dot,
    input  logic [PE_COUNT-1:0]                   issue_mask,
    input  logic signed [PE_COUNT*DATA_WIDTH-1:0] elem_out,
    input  logic signed [PE_COUNT*DATA_WIDTH-1:0] dot_out,
    output logic                                  stall,
    output logic                                  rf_valid,
    input  logic                                  rf_ready,
    output logic [REG_ADDR_WIDTH-1:0]             rf_addr,
    output logic [PE_COUNT-1:0]                   rf_wmask,
    output logic [PE_COUNT*DATA_WIDTH-1:0]        rf_wdata,
    output logic                                  overflow
);

    localparam int unsigned VEC_W = PE_COUNT * DATA_WIDTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned INF_W = $clog2(EXEC_LATENCY + 1);
    localparam int unsigned SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    typedef struct packed {
        logic                      vld;
        logic [REG_ADDR_WIDTH-1:0] dst;
        logic                      dot;
        logic [PE_COUNT-1:0]       mask;
    } tag_t;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] dst;
        logic [PE_COUNT-1:0]       mask;
        logic [VEC_W-1:0]          data;
    } entry_t;

    tag_t             tag_q [EXEC_LATENCY];
    tag_t             tag_d [EXEC_LATENCY];
    entry_t           mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;

    logic [CNT_W-1:0] count_c;
    logic [INF_W-1:0] inflight_c;
    logic             full_c;
    logic             accept_c;
    logic             pop_c;
    logic             push_req_c;
    logic             push_c;
    tag_t             cap_c;
    entry_t           push_ent_c;
    entry_t           head_c;

    // Number of valid tags still travelling through the execute pipe.
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < int'(EXEC_LATENCY); i++) begin
            inflight_c = inflight_c + INF_W'(tag_q[i].vld);
        end
    end

    // Occupancy and credit stall, from registered state only.
    always_comb begin
        count_c = wr_ptr_q - rd_ptr_q;
        full_c  = (count_c == CNT_W'(FIFO_DEPTH));
        stall   = (SUM_W'(count_c) + SUM_W'(inflight_c)) >= SUM_W'(FIFO_DEPTH);
    end

    // FIFO head drives the register file port; zeroed while empty.
    always_comb begin
        head_c   = mem_q[rd_ptr_q[PTR_W-1:0]];
        rf_valid = (count_c != '0);
        rf_addr  = rf_valid ? head_c.dst  : '0;
        rf_wmask = rf_valid ? head_c.mask : '0;
        rf_wdata = rf_valid ? head_c.data : '0;
        overflow = overflow_q;
    end

    // Next state: tag pipe shift, capture/push, pop and sticky overflow.
    always_comb begin
        cap_c       = tag_q[EXEC_LATENCY-1];
        accept_c    = issue_valid & ~stall;
        pop_c       = rf_valid & rf_ready;
        push_req_c  = cap_c.vld & (|cap_c.mask);
        push_c      = push_req_c & (~full_c | pop_c);

        push_ent_c.dst  = cap_c.dst;
        push_ent_c.mask = cap_c.mask;
        push_ent_c.data = cap_c.dot ? VEC_W'(dot_out) : VEC_W'(elem_out);

        wr_ptr_d   = wr_ptr_q + CNT_W'(push_c);
        rd_ptr_d   = rd_ptr_q + CNT_W'(pop_c);
        overflow_d = overflow_q | (issue_valid & stall) | (push_req_c & ~push_c);

        tag_d[0].vld  = accept_c;
        tag_d[0].dst  = issue_dst;
        tag_d[0].dot  = issue_src_dot;
        tag_d[0].mask = issue_mask;
        for (int i = 1; i < int'(EXEC_LATENCY); i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(EXEC_LATENCY); i++) begin
                tag_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(EXEC_LATENCY); i++) begin
                tag_q[i] <= tag_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (rstn && push_c) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_ent_c;
        end
    end

endmodule
